// File: rtl/rbm_pkg.sv
// rtl/rbm_pkg.sv - shared widths, clamp values and FSM states for the RBM hidden accumulator
package rbm_pkg;

  localparam int BITLENGTH = 16;
  localparam logic [BITLENGTH-1:0] INF = 16'h7FFF;
  localparam logic [BITLENGTH-1:0] NEG_INF = 16'h8001;
  localparam int MAX_LEN_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/i_ap_adder.sv
// rtl/i_ap_adder.sv - combinational two's complement saturating adder, clamps to +/-INF
module i_ap_adder #(
  parameter int BITLENGTH = 16,
  parameter logic [BITLENGTH-1:0] INF = 16'h7FFF
) (
  input  logic [BITLENGTH-1:0] a,
  input  logic [BITLENGTH-1:0] b,
  output logic [BITLENGTH-1:0] sum
);

  logic [BITLENGTH-1:0] tmp;
  logic                 pos_ovf;
  logic                 neg_ovf;

  assign tmp     = a + b;
  assign pos_ovf = !a[BITLENGTH-1] && !b[BITLENGTH-1] && tmp[BITLENGTH-1];
  assign neg_ovf = a[BITLENGTH-1] && b[BITLENGTH-1] && !tmp[BITLENGTH-1];

  // Negative clamp is -INF, so the most negative code is never produced by clamping.
  always_comb begin
    sum = tmp;
    if (pos_ovf) sum = INF;
    else if (neg_ovf) sum = -INF;
  end

endmodule

// File: rtl/rbm_hidden_accum.sv
// rtl/rbm_hidden_accum.sv - streams (w, v) beats into one saturated RBM hidden pre-activation per vector
module rbm_hidden_accum
  import rbm_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT,
  parameter int CNT_W   = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BITLENGTH-1:0] bias,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITLENGTH-1:0] in_w,
  input  logic                 in_v,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BITLENGTH-1:0] out_sum,
  output logic                 out_sat,
  output logic                 out_len_err,
  output logic [CNT_W-1:0]     out_count
);

  state_t               state;
  logic [BITLENGTH-1:0] acc;
  logic [CNT_W-1:0]     count;
  logic                 sat;
  logic                 len_err;

  logic [BITLENGTH-1:0] term;
  logic [BITLENGTH-1:0] a_op;
  logic [BITLENGTH-1:0] add_sum;
  logic [BITLENGTH-1:0] tmp;
  logic                 sat_step;
  logic                 accept;
  logic [CNT_W-1:0]     count_nxt;
  logic                 at_max;

  assign term   = in_v ? in_w : '0;
  assign a_op   = (state == IDLE) ? bias : acc;
  assign accept = in_valid && in_ready;

  i_ap_adder #(
    .BITLENGTH(BITLENGTH),
    .INF      (INF)
  ) u_adder (
    .a  (a_op),
    .b  (term),
    .sum(add_sum)
  );

  // Mirror the adder's overflow equations to flag that this step clamped.
  assign tmp      = a_op + term;
  assign sat_step = (!a_op[BITLENGTH-1] && !term[BITLENGTH-1] && tmp[BITLENGTH-1]) ||
                    (a_op[BITLENGTH-1] && term[BITLENGTH-1] && !tmp[BITLENGTH-1]);

  assign count_nxt = count + CNT_W'(1);
  assign at_max    = (count_nxt == CNT_W'(MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      sat     <= 1'b0;
      len_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc     <= add_sum;
            count   <= CNT_W'(1);
            sat     <= sat_step;
            len_err <= 1'b0;
            state   <= (in_last || MAX_LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= add_sum;
            count <= count_nxt;
            sat   <= sat | sat_step;
            if (in_last) begin
              state <= DONE;
            end else if (at_max) begin
              state   <= DONE;
              len_err <= 1'b1;
            end
          end
        end
        DONE: begin
          // Result registers stay put until the next vector's first beat overwrites them.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state != DONE);
  assign out_valid   = (state == DONE);
  assign out_sum     = acc;
  assign out_count   = count;
  assign out_sat     = sat;
  assign out_len_err = len_err;

endmodule

// File: tb/tb_rbm_hidden_accum.sv
// tb/tb_rbm_hidden_accum.sv - directed self-checking bench for rbm_hidden_accum
module tb_rbm_hidden_accum;

  logic        clk;
  logic        rst_n;
  logic [15:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_w;
  logic        in_v;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_sat;
  logic        out_len_err;
  logic [2:0]  out_count;

  int n_checks;
  int n_fail;

  rbm_hidden_accum #(
    .MAX_LEN(4),
    .CNT_W  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_w       (in_w),
    .in_v       (in_v),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_sat    (out_sat),
    .out_len_err(out_len_err),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one beat and holds it until accepted, bounded by a cycle budget.
  task automatic send_beat(input logic [15:0] w, input logic v, input logic last);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("beat_ready_timeout", 32'(in_ready), 32'd1);
    in_w     = w;
    in_v     = v;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_w      = '0;
    in_v      = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_sat", 32'(out_sat), 32'd0);
    check("rst_len_err", 32'(out_len_err), 32'd0);

    // Basic sum: 10 + 5 + 0 - 3 = 12
    bias = 16'd10;
    send_beat(16'd5, 1'b1, 1'b0);
    send_beat(16'd7, 1'b0, 1'b0);
    send_beat(16'hFFFD, 1'b1, 1'b1);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_sum", 32'(out_sum), 32'd12);
    check("basic_count", 32'(out_count), 32'd3);
    check("basic_sat", 32'(out_sat), 32'd0);
    check("basic_len_err", 32'(out_len_err), 32'd0);
    take_result();
    check("basic_drop_valid", 32'(out_valid), 32'd0);

    // Positive clamp, then recovery: 7000+2000 -> 7FFF, -1000 -> 6FFF
    bias = 16'h7000;
    send_beat(16'h2000, 1'b1, 1'b0);
    send_beat(16'hF000, 1'b1, 1'b1);
    check("pos_sum", 32'(out_sum), 32'h6FFF);
    check("pos_sat", 32'(out_sat), 32'd1);
    check("pos_count", 32'(out_count), 32'd2);
    take_result();

    // Negative clamp: -7000 + -2000 -> 8001
    bias = 16'h9000;
    send_beat(16'hE000, 1'b1, 1'b1);
    check("neg_sum", 32'(out_sum), 32'h8001);
    check("neg_sat", 32'(out_sat), 32'd1);
    check("neg_count", 32'(out_count), 32'd1);

    // Backpressure: an offered beat must not be taken while the result waits
    bias     = 16'd3;
    in_w     = 16'd100;
    in_v     = 1'b1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_sum", 32'(out_sum), 32'h8001);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    send_beat(16'd4, 1'b1, 1'b1);
    check("bp_new_sum", 32'(out_sum), 32'd7);
    check("bp_new_sat", 32'(out_sat), 32'd0);
    take_result();

    // Length guard at MAX_LEN=4: six beats of +1, last on the sixth
    bias = 16'd0;
    for (int i = 0; i < 4; i++) send_beat(16'd1, 1'b1, 1'b0);
    check("len_valid", 32'(out_valid), 32'd1);
    check("len_sum", 32'(out_sum), 32'd4);
    check("len_count", 32'(out_count), 32'd4);
    check("len_err", 32'(out_len_err), 32'd1);
    take_result();
    send_beat(16'd1, 1'b1, 1'b0);
    send_beat(16'd1, 1'b1, 1'b1);
    check("len_tail_sum", 32'(out_sum), 32'd2);
    check("len_tail_count", 32'(out_count), 32'd2);
    check("len_tail_err", 32'(out_len_err), 32'd0);
    take_result();

    // Async reset mid-vector, asserted away from any clock edge
    bias = 16'd5;
    send_beat(16'd3, 1'b1, 1'b0);
    send_beat(16'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum", 32'(out_sum), 32'd0);
    check("arst_count", 32'(out_count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    bias = 16'd1;
    send_beat(16'd1, 1'b1, 1'b1);
    check("arst_after_sum", 32'(out_sum), 32'd2);
    check("arst_after_count", 32'(out_count), 32'd1);
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
